// File: rtl/rtc_time_reader.sv
// RTC time reader: bus master that reads hours, minutes and seconds from the
// external RTC over the multiplexed AD/WR/RD/CS bus. The three values go into
// shadow registers first and are committed together as one coherent snapshot.
// All bus outputs float (Hi-Z) when the block is idle.
module rtc_time_reader #(
    parameter logic [7:0]  ADDR_HORA = 8'h23,
    parameter logic [7:0]  ADDR_MIN  = 8'h22,
    parameter logic [7:0]  ADDR_SEG  = 8'h21,
    parameter int unsigned SLOT_LEN  = 35
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       chl,
    input  logic [7:0] ADin,
    output logic [7:0] ADout,
    output logic       ad,
    output logic       wr,
    output logic       rd,
    output logic       cs,
    output logic [7:0] hora,
    output logic [7:0] min,
    output logic [7:0] seg,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CntW = $clog2(SLOT_LEN);

    typedef enum logic [0:0] {StIdle, StXfer} state_t;

    state_t            r_state;
    logic [CntW-1:0]   r_cont;
    logic [1:0]        r_slot;
    logic              r_chl;
    logic              r_bus_en;    // strobes (ad/wr/rd/cs) driven
    logic              r_adout_en;  // address driven on ADout
    logic [7:0]        r_adout;
    logic              r_ad, r_wr, r_rd, r_cs;
    logic [7:0]        r_sh_hora, r_sh_min, r_sh_seg;
    logic [7:0]        r_hora, r_min, r_seg;
    logic              r_busy, r_done;

    logic              w_chl_rise;
    logic [CntW-1:0]   w_cont_nxt;
    logic [7:0]        w_addr;

    assign w_chl_rise = chl & ~r_chl;
    assign w_cont_nxt = r_cont + 1'b1;

    // Register address for the slot currently being read
    always_comb begin
        w_addr = ADDR_SEG;
        case (r_slot)
            2'd0:    w_addr = ADDR_HORA;
            2'd1:    w_addr = ADDR_MIN;
            default: w_addr = ADDR_SEG;
        endcase
    end

    // Read sequencer: outputs are registered so that each action is visible
    // during the cycle whose cont value it is listed under.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_cont     <= '0;
            r_slot     <= 2'd0;
            r_chl      <= 1'b0;
            r_bus_en   <= 1'b0;
            r_adout_en <= 1'b0;
            r_adout    <= 8'h00;
            r_ad       <= 1'b1;
            r_wr       <= 1'b1;
            r_rd       <= 1'b1;
            r_cs       <= 1'b1;
            r_sh_hora  <= 8'h00;
            r_sh_min   <= 8'h00;
            r_sh_seg   <= 8'h00;
            r_hora     <= 8'h00;
            r_min      <= 8'h00;
            r_seg      <= 8'h00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_chl  <= chl;
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_chl_rise) begin
                        r_state    <= StXfer;
                        r_slot     <= 2'd0;
                        r_cont     <= '0;
                        r_busy     <= 1'b1;
                        r_bus_en   <= 1'b1;
                        r_adout_en <= 1'b0;
                        r_ad       <= 1'b1;
                        r_wr       <= 1'b1;
                        r_rd       <= 1'b1;
                        r_cs       <= 1'b1;
                    end
                end
                StXfer: begin
                    // Bus data is valid while rd is low; sample at cont 22
                    if (int'(r_cont) == 22) begin
                        case (r_slot)
                            2'd0:    r_sh_hora <= ADin;
                            2'd1:    r_sh_min  <= ADin;
                            default: r_sh_seg  <= ADin;
                        endcase
                    end
                    if (int'(r_cont) == int'(SLOT_LEN) - 1) begin
                        r_cont <= '0;
                        // slot 3 never occurs; treat anything >= 2 as the last
                        if (r_slot >= 2'd2) begin
                            r_hora     <= r_sh_hora;
                            r_min      <= r_sh_min;
                            r_seg      <= r_sh_seg;
                            r_done     <= 1'b1;
                            r_busy     <= 1'b0;
                            r_bus_en   <= 1'b0;
                            r_adout_en <= 1'b0;
                            r_slot     <= 2'd0;
                            r_state    <= StIdle;
                        end else begin
                            r_slot     <= r_slot + 2'd1;
                            r_adout_en <= 1'b0;
                            r_ad       <= 1'b1;
                            r_wr       <= 1'b1;
                            r_rd       <= 1'b1;
                            r_cs       <= 1'b1;
                        end
                    end else begin
                        r_cont <= w_cont_nxt;
                        case (int'(w_cont_nxt))
                            1:  r_ad <= 1'b0;
                            2:  r_cs <= 1'b0;
                            3:  r_wr <= 1'b0;
                            4: begin
                                r_adout_en <= 1'b1;
                                r_adout    <= w_addr;
                            end
                            8:  r_wr <= 1'b1;
                            9:  r_cs <= 1'b1;
                            10: r_ad <= 1'b1;
                            11: r_adout_en <= 1'b0;
                            15: r_cs <= 1'b0;
                            16: r_rd <= 1'b0;
                            23: r_rd <= 1'b1;
                            24: r_cs <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign ADout = r_adout_en ? r_adout : 8'hzz;
    assign ad    = r_bus_en ? r_ad : 1'bz;
    assign wr    = r_bus_en ? r_wr : 1'bz;
    assign rd    = r_bus_en ? r_rd : 1'bz;
    assign cs    = r_bus_en ? r_cs : 1'bz;
    assign hora  = r_hora;
    assign min   = r_min;
    assign seg   = r_seg;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_rtc_time_reader.sv
// Bench for rtc_time_reader: a behavioural RTC answers reads, expected
// snapshots and addresses are queued at stimulus time and checked when the
// DUT produces them.
module tb_rtc_time_reader;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       chl   = 1'b0;
    wire  [7:0] ad_in;
    wire  [7:0] ad_out;
    wire        ad, wr, rd, cs;
    logic [7:0] hora, min, seg;
    logic       busy, done;

    int checks = 0;
    int errors = 0;

    // RTC model state
    logic [7:0] rtc_h = 8'h00, rtc_m = 8'h00, rtc_s = 8'h00;
    logic [7:0] rtc_lat = 8'h00;
    logic [7:0] rtc_sel;

    // Scoreboards
    logic [23:0] exp_q[$];
    logic [7:0]  addr_q[$];
    logic [7:0]  cur_h = 8'h00, cur_m = 8'h00, cur_s = 8'h00;
    int          done_cnt = 0;
    bit          addr_seen = 1'b0;

    rtc_time_reader dut (
        .clock (clock),
        .reset (reset),
        .chl   (chl),
        .ADin  (ad_in),
        .ADout (ad_out),
        .ad    (ad),
        .wr    (wr),
        .rd    (rd),
        .cs    (cs),
        .hora  (hora),
        .min   (min),
        .seg   (seg),
        .busy  (busy),
        .done  (done)
    );

    always #5 clock = ~clock;

    always_comb begin
        case (rtc_lat)
            8'h23:   rtc_sel = rtc_h;
            8'h22:   rtc_sel = rtc_m;
            8'h21:   rtc_sel = rtc_s;
            default: rtc_sel = 8'hee;
        endcase
    end
    assign ad_in = (rd === 1'b0 && cs === 1'b0) ? rtc_sel : 8'hff;

    always @(posedge clock) begin
        if (cs === 1'b0 && wr === 1'b0 && ad_out !== 8'hzz) rtc_lat <= ad_out;
    end

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Snapshot checker: pops expected values on each done pulse
    always @(negedge clock) begin
        if (done === 1'b1) begin
            done_cnt++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_done: observed done=1 expected no done");
            end
            if (exp_q.size() != 0) begin
                logic [23:0] e;
                e = exp_q.pop_front();
                chk8("commit_hora", hora, e[23:16]);
                chk8("commit_min", min, e[15:8]);
                chk8("commit_seg", seg, e[7:0]);
                cur_h = e[23:16];
                cur_m = e[15:8];
                cur_s = e[7:0];
            end
        end
    end

    // Address checker: first driven value in each wr-low window
    always @(negedge clock) begin
        if (wr === 1'b0 && ad_out !== 8'hzz) begin
            if (!addr_seen) begin
                addr_seen = 1'b1;
                checks++;
                assert (addr_q.size() != 0) else begin
                    errors++;
                    $error("FAIL addr_extra: observed %h expected none", ad_out);
                end
                if (addr_q.size() != 0) chk8("addr_order", ad_out, addr_q.pop_front());
            end
        end else if (wr !== 1'b0) begin
            addr_seen = 1'b0;
        end
    end

    task automatic expect_read(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        rtc_h = h;
        rtc_m = m;
        rtc_s = s;
        exp_q.push_back({h, m, s});
        addr_q.push_back(8'h23);
        addr_q.push_back(8'h22);
        addr_q.push_back(8'h21);
    endtask

    // Pulse chl; on return the DUT is in its first XFER cycle (cycle 0)
    task automatic pulse_chl();
        chl = 1'b1;
        @(posedge clock);
        #1 chl = 1'b0;
    endtask

    task automatic bus_z(input string tag);
        chk8({tag, "_adout"}, ad_out, 8'hzz);
        chk1({tag, "_ad"}, ad, 1'bz);
        chk1({tag, "_wr"}, wr, 1'bz);
        chk1({tag, "_rd"}, rd, 1'bz);
        chk1({tag, "_cs"}, cs, 1'bz);
    endtask

    // Runs one full read after pulse_chl; k is the XFER cycle index
    task automatic run_read(input bit detailed, input bit chg, input logic [7:0] nh,
                            input logic [7:0] nm, input logic [7:0] ns);
        logic [7:0] oh, om, os;
        oh = cur_h;
        om = cur_m;
        os = cur_s;
        for (int k = 0; k <= 106; k++) begin
            @(negedge clock);
            if (detailed) begin
                case (k)
                    0: begin
                        chk1("busy_start", busy, 1'b1);
                        chk1("ad_c0", ad, 1'b1);
                        chk8("adout_c0", ad_out, 8'hzz);
                    end
                    1:  chk1("ad_c1", ad, 1'b0);
                    2:  chk1("cs_c2", cs, 1'b0);
                    3: begin
                        chk1("wr_c3", wr, 1'b0);
                        chk8("adout_c3", ad_out, 8'hzz);
                    end
                    4:  chk8("adout_c4", ad_out, 8'h23);
                    10: chk8("adout_c10", ad_out, 8'h23);
                    11: chk8("adout_c11", ad_out, 8'hzz);
                    15: chk1("rd_c15", rd, 1'b1);
                    16: chk1("rd_c16", rd, 1'b0);
                    22: chk1("rd_c22", rd, 1'b0);
                    23: chk1("rd_c23", rd, 1'b1);
                    39: chk8("adout_s1", ad_out, 8'h22);
                    default: ;
                endcase
            end
            if (chg && k == 40) begin
                rtc_h = nh;
                rtc_m = nm;
                rtc_s = ns;
                exp_q[0][15:0] = {nm, ns};
            end
            if (k == 60 || k == 104) begin
                chk8("hold_hora", hora, oh);
                chk8("hold_min", min, om);
                chk8("hold_seg", seg, os);
                chk1("done_early", done, 1'b0);
            end
            if (k == 105) begin
                chk1("done_pulse", done, 1'b1);
                chk1("busy_end", busy, 1'b0);
                bus_z("end");
            end
            if (k == 106) chk1("done_one_cycle", done, 1'b0);
        end
        checks++;
        assert (addr_q.size() == 0) else begin
            errors++;
            $error("FAIL addr_count: observed %0d left expected 0", addr_q.size());
        end
    endtask

    initial begin
        int d0;

        // Reset
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        bus_z("rst");
        chk8("rst_hora", hora, 8'h00);
        chk8("rst_min", min, 8'h00);
        chk8("rst_seg", seg, 8'h00);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        @(posedge clock);
        #1;

        // Single read with detailed timing
        expect_read(8'h12, 8'h34, 8'h56);
        pulse_chl();
        run_read(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        chk8("read1_hora", hora, 8'h12);

        // Coherence: RTC changes after slot 0 is captured
        @(posedge clock);
        #1;
        expect_read(8'h01, 8'h02, 8'h03);
        pulse_chl();
        run_read(1'b0, 1'b1, 8'h0a, 8'h0b, 8'h0c);
        chk8("coh_hora", hora, 8'h01);
        chk8("coh_min", min, 8'h0b);

        // Retrigger: level held high plus an extra edge mid-read
        @(posedge clock);
        #1;
        expect_read(8'h21, 8'h43, 8'h05);
        d0 = done_cnt;
        chl = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(posedge clock);
            #1;
            if (c == 50) chl = 1'b0;
            if (c == 51) chl = 1'b1;
        end
        chl = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        assert (done_cnt - d0 == 1) else begin
            errors++;
            $error("FAIL retrigger_done: observed %0d expected 1", done_cnt - d0);
        end
        addr_q.delete();

        // Reset mid-read at slot 1, cont 20
        expect_read(8'h77, 8'h88, 8'h99);
        pulse_chl();
        for (int k = 0; k <= 55; k++) @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        bus_z("midrst");
        chk8("midrst_hora", hora, 8'h00);
        chk8("midrst_seg", seg, 8'h00);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_done", done, 1'b0);
        exp_q.delete();
        addr_q.delete();
        cur_h = 8'h00;
        cur_m = 8'h00;
        cur_s = 8'h00;
        d0 = done_cnt;
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        checks++;
        assert (done_cnt == d0) else begin
            errors++;
            $error("FAIL midrst_nodone: observed %0d expected %0d", done_cnt, d0);
        end

        // Normal read after the aborted one
        expect_read(8'h77, 8'h88, 8'h99);
        pulse_chl();
        run_read(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        chk8("post_seg", seg, 8'h99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
